io_handshake_controller: RTL and testbench

Sequencing controller for the processor's I/O path: it stalls the core on every IN/OUT instruction until the operator presses the confirm pushbutton. On IN it captures the switch value for register write-back; on OUT it latches the register value that drives the 7-segment display chain. It sits between the control unit (IOE/IOsel decode), the board pushbutton and switches, and the binary-to-BCD display path.

---
 rtl/io_ctrl_pkg.sv | 19 +
 rtl/confirm_debouncer.sv | 52 +++++
 rtl/io_handshake_controller.sv | 85 ++++++++
 tb/tb_io_handshake_controller.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_ctrl_pkg.sv
// Shared types and widths for the I/O handshake controller.
// The FSM state is also exported on a debug port so checkers can follow it.
package io_ctrl_pkg;

    localparam int SWITCH_WIDTH = 10;
    localparam int DATA_WIDTH   = 32;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        WAIT_RELEASE = 2'd2,
        DONE         = 2'd3
    } io_state_e;

    function automatic logic [DATA_WIDTH-1:0] zero_extend_switch(input logic [SWITCH_WIDTH-1:0] sw);
        return {{(DATA_WIDTH - SWITCH_WIDTH){1'b0}}, sw};
    endfunction

endpackage

// File: rtl/confirm_debouncer.sv
// Two-flop synchronizer plus stability counter for the active-low confirm button.
// Emits one-cycle press/release pulses on the same edge the debounced level flips.
module confirm_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic confirm_n,
    output logic press_pulse,
    output logic release_pulse,
    output logic debounced_n
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_meta;
    logic          sync_level;
    logic          deb_level;
    logic [CW-1:0] count;
    logic          differ;
    logic          settle;

    assign differ = (sync_level != deb_level);
    // The level has differed for DEBOUNCE_CYCLES consecutive edges, including this one.
    assign settle = differ && (count == CNT_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_meta  <= 1'b1;
            sync_level <= 1'b1;
            deb_level  <= 1'b1;
            count      <= '0;
        end else begin
            sync_meta  <= confirm_n;
            sync_level <= sync_meta;
            if (!differ) begin
                count <= '0;
            end else if (settle) begin
                deb_level <= sync_level;
                count     <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    assign press_pulse   = settle && !sync_level;
    assign release_pulse = settle &&  sync_level;
    assign debounced_n   = deb_level;

endmodule

// File: rtl/io_handshake_controller.sv
// Stalls the core on IN/OUT until the operator confirms with the pushbutton,
// capturing switches (IN) or latching the display value (OUT) on the press.
module io_handshake_controller
    import io_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    io_enable,
    input  logic                    io_input,
    input  logic                    confirm_n,
    input  logic [SWITCH_WIDTH-1:0] switch_dado,
    input  logic [DATA_WIDTH-1:0]   entrada_dado,
    output logic                    stall,
    output logic [DATA_WIDTH-1:0]   saida_dado,
    output logic [DATA_WIDTH-1:0]   display_value,
    output logic                    io_done,
    output io_state_e               debug_state
);

    io_state_e state;
    logic      press_pulse;
    logic      release_pulse;
    logic      debounced_n;

    confirm_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clock        (clock),
        .reset        (reset),
        .confirm_n    (confirm_n),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .debounced_n  (debounced_n)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            saida_dado    <= '0;
            display_value <= '0;
            io_done       <= 1'b0;
        end else begin
            io_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (io_enable) state <= WAIT_PRESS;
                end
                WAIT_PRESS: begin
                    if (!io_enable) begin
                        state <= IDLE;
                    end else if (press_pulse) begin
                        if (io_input) saida_dado <= zero_extend_switch(switch_dado);
                        else          display_value <= entrada_dado;
                        state <= WAIT_RELEASE;
                    end
                end
                // The capture is already done, so io_enable no longer matters here.
                WAIT_RELEASE: begin
                    if (release_pulse) begin
                        state   <= DONE;
                        io_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Zero-latency stall so the PC never advances past a fresh I/O instruction.
    assign stall = ((state == IDLE) && io_enable) ||
                   (state == WAIT_PRESS) || (state == WAIT_RELEASE);

    assign debug_state = state;

    logic unused_debounced;
    assign unused_debounced = debounced_n;

endmodule

// File: tb/tb_io_handshake_controller.sv
// Bench for io_handshake_controller: vector table, directed corner sequences,
// and random stimulus against a sample-history reference model.
module tb_io_handshake_controller;
  import io_ctrl_pkg::*;

  localparam int D = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        io_enable = 1'b0;
  logic        io_input = 1'b0;
  logic        confirm_n = 1'b1;
  logic [9:0]  switch_dado = '0;
  logic [31:0] entrada_dado = '0;
  logic        stall;
  logic [31:0] saida_dado;
  logic [31:0] display_value;
  logic        io_done;
  io_state_e   debug_state;

  int n_checks = 0;
  int n_fail = 0;
  int done_seen = 0;

  io_handshake_controller #(.DEBOUNCE_CYCLES(D)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_enable    (io_enable),
    .io_input     (io_input),
    .confirm_n    (confirm_n),
    .switch_dado  (switch_dado),
    .entrada_dado (entrada_dado),
    .stall        (stall),
    .saida_dado   (saida_dado),
    .display_value(display_value),
    .io_done      (io_done),
    .debug_state  (debug_state)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic        hist[$];
  logic        m_deb = 1'b1;
  io_state_e   m_state = IDLE;
  logic [31:0] m_saida = '0;
  logic [31:0] m_disp = '0;
  logic        m_done = 1'b0;

  // Debounced level flips once the last D synchronized samples (raw samples
  // delayed two edges) all agree and differ from the current level.
  task automatic model_edge();
    logic press_e, rel_e, all_same, v;
    int n;
    press_e = 1'b0;
    rel_e = 1'b0;
    if (reset) begin
      hist.delete();
      for (int k = 0; k < D + 2; k++) hist.push_back(1'b1);
      m_deb = 1'b1;
      m_state = IDLE;
      m_saida = '0;
      m_disp = '0;
      m_done = 1'b0;
      return;
    end
    n = hist.size();
    v = hist[n-2];
    all_same = 1'b1;
    for (int k = 0; k < D; k++) if (hist[n-2-k] != v) all_same = 1'b0;
    if (all_same && (v != m_deb)) begin
      m_deb = v;
      press_e = (v == 1'b0);
      rel_e = (v == 1'b1);
    end
    hist.push_back(confirm_n);
    if (hist.size() > D + 2) void'(hist.pop_front());
    m_done = 1'b0;
    case (m_state)
      IDLE: if (io_enable) m_state = WAIT_PRESS;
      WAIT_PRESS: begin
        if (!io_enable) m_state = IDLE;
        else if (press_e) begin
          if (io_input) m_saida = {22'b0, switch_dado};
          else m_disp = entrada_dado;
          m_state = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: if (rel_e) begin m_state = DONE; m_done = 1'b1; end
      DONE: m_state = IDLE;
      default: m_state = IDLE;
    endcase
  endtask

  function automatic logic model_stall();
    return ((m_state == IDLE) && io_enable) || (m_state == WAIT_PRESS) || (m_state == WAIT_RELEASE);
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("model_stall", 32'(stall), 32'(model_stall()));
    check("model_saida", saida_dado, m_saida);
    check("model_display", display_value, m_disp);
    check("model_done", 32'(io_done), 32'(m_done));
    check("model_state", 32'(debug_state), 32'(m_state));
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    if (io_done === 1'b1) done_seen++;
    compare_model();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive(input logic en, input logic sel, input logic cn,
                       input logic [9:0] sw, input logic [31:0] din);
    io_enable = en;
    io_input = sel;
    confirm_n = cn;
    switch_dado = sw;
    entrada_dado = din;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          cycles;
    logic        en;
    logic        sel;
    logic        cn;
    logic [9:0]  sw;
    logic [31:0] din;
    logic        exp_stall;
    logic [31:0] exp_saida;
    logic [31:0] exp_disp;
    logic        exp_done;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int done_before;
    logic cur_cn, cur_en;
    int hold;

    vecs.push_back('{0, 1'b1, 1'b1, 1'b1, 10'h2A5, 32'h0,        1'b1, 32'h0,     32'h0,        1'b0});
    vecs.push_back('{5, 1'b1, 1'b1, 1'b0, 10'h2A5, 32'h0,        1'b1, 32'h0,     32'h0,        1'b0});
    vecs.push_back('{1, 1'b1, 1'b1, 1'b0, 10'h2A5, 32'h0,        1'b1, 32'h2A5,   32'h0,        1'b0});
    vecs.push_back('{5, 1'b1, 1'b1, 1'b1, 10'h2A5, 32'h0,        1'b1, 32'h2A5,   32'h0,        1'b0});
    vecs.push_back('{1, 1'b1, 1'b1, 1'b1, 10'h2A5, 32'h0,        1'b0, 32'h2A5,   32'h0,        1'b1});
    vecs.push_back('{1, 1'b0, 1'b1, 1'b1, 10'h2A5, 32'h0,        1'b0, 32'h2A5,   32'h0,        1'b0});
    vecs.push_back('{1, 1'b1, 1'b0, 1'b1, 10'h000, 32'hDEADBEEF, 1'b1, 32'h2A5,   32'h0,        1'b0});
    vecs.push_back('{5, 1'b1, 1'b0, 1'b0, 10'h000, 32'hDEADBEEF, 1'b1, 32'h2A5,   32'h0,        1'b0});
    vecs.push_back('{1, 1'b1, 1'b0, 1'b0, 10'h000, 32'hDEADBEEF, 1'b1, 32'h2A5,   32'hDEADBEEF, 1'b0});
    vecs.push_back('{6, 1'b1, 1'b0, 1'b1, 10'h000, 32'hDEADBEEF, 1'b0, 32'h2A5,   32'hDEADBEEF, 1'b1});
    vecs.push_back('{1, 1'b1, 1'b1, 1'b1, 10'h005, 32'h12345678, 1'b1, 32'h2A5,   32'hDEADBEEF, 1'b0});
    vecs.push_back('{1, 1'b1, 1'b1, 1'b1, 10'h005, 32'h12345678, 1'b1, 32'h2A5,   32'hDEADBEEF, 1'b0});
    vecs.push_back('{6, 1'b1, 1'b1, 1'b0, 10'h005, 32'h12345678, 1'b1, 32'h5,     32'hDEADBEEF, 1'b0});
    vecs.push_back('{6, 1'b1, 1'b1, 1'b1, 10'h005, 32'h12345678, 1'b0, 32'h5,     32'hDEADBEEF, 1'b1});
    vecs.push_back('{1, 1'b0, 1'b1, 1'b1, 10'h005, 32'h12345678, 1'b0, 32'h5,     32'hDEADBEEF, 1'b0});

    // clock/reset
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 10'h0, 32'h0);
    ticks(2);
    reset = 1'b0;
    ticks(2);
    check("reset_stall", 32'(stall), 32'h0);
    check("reset_saida", saida_dado, 32'h0);
    check("reset_display", display_value, 32'h0);
    check("reset_done", 32'(io_done), 32'h0);
    check("reset_state", 32'(debug_state), 32'(IDLE));

    // table-driven IN / OUT / IN-after-OUT
    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].sel, vecs[i].cn, vecs[i].sw, vecs[i].din);
      #1;
      ticks(vecs[i].cycles);
      check($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].exp_stall));
      check($sformatf("vec%0d_saida", i), saida_dado, vecs[i].exp_saida);
      check($sformatf("vec%0d_display", i), display_value, vecs[i].exp_disp);
      check($sformatf("vec%0d_done", i), 32'(io_done), 32'(vecs[i].exp_done));
    end

    // bounce shorter than the debounce window never captures
    drive(1'b1, 1'b1, 1'b1, 10'h3FF, 32'hCAFEF00D);
    tick();
    for (int i = 0; i < 20; i++) begin
      confirm_n = ((i >> 1) & 1) ? 1'b1 : 1'b0;
      tick();
    end
    confirm_n = 1'b1;
    ticks(10);
    check("bounce_state", 32'(debug_state), 32'(WAIT_PRESS));
    check("bounce_stall", 32'(stall), 32'h1);
    check("bounce_saida", saida_dado, 32'h5);
    check("bounce_display", display_value, 32'hDEADBEEF);

    // abort from WAIT_PRESS
    io_enable = 1'b0;
    tick();
    check("abort_state", 32'(debug_state), 32'(IDLE));
    check("abort_stall", 32'(stall), 32'h0);
    check("abort_saida", saida_dado, 32'h5);
    check("abort_display", display_value, 32'hDEADBEEF);

    // button already held when the instruction arrives
    drive(1'b0, 1'b1, 1'b0, 10'h155, 32'h0);
    ticks(10);
    io_enable = 1'b1;
    ticks(10);
    check("held_no_capture", saida_dado, 32'h5);
    check("held_state", 32'(debug_state), 32'(WAIT_PRESS));
    confirm_n = 1'b1;
    ticks(10);
    check("held_release_ignored", 32'(debug_state), 32'(WAIT_PRESS));
    confirm_n = 1'b0;
    ticks(6);
    check("held_fresh_press", saida_dado, 32'h155);
    check("held_wait_release", 32'(debug_state), 32'(WAIT_RELEASE));

    // reset while waiting for release
    reset = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 10'h0, 32'h0);
    tick();
    check("rst_state", 32'(debug_state), 32'(IDLE));
    check("rst_saida", saida_dado, 32'h0);
    check("rst_display", display_value, 32'h0);
    check("rst_stall", 32'(stall), 32'h0);
    reset = 1'b0;
    ticks(3);

    // back-to-back IN instructions
    done_before = done_seen;
    drive(1'b1, 1'b1, 1'b1, 10'h003, 32'h0);
    tick();
    confirm_n = 1'b0;
    ticks(6);
    check("b2b_first", saida_dado, 32'h3);
    confirm_n = 1'b1;
    ticks(6);
    check("b2b_first_done", 32'(io_done), 32'h1);
    switch_dado = 10'h007;
    tick();
    check("b2b_restall", 32'(stall), 32'h1);
    tick();
    confirm_n = 1'b0;
    ticks(6);
    check("b2b_second", saida_dado, 32'h7);
    confirm_n = 1'b1;
    ticks(6);
    io_enable = 1'b0;
    tick();
    check("b2b_done_count", 32'(done_seen - done_before), 32'd2);

    // randomized traffic against the model
    cur_cn = 1'b1;
    cur_en = 1'b0;
    hold = 8;
    for (int c = 0; c < 1500; c++) begin
      if (hold == 0) begin
        cur_cn = ~cur_cn;
        hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(5, 14));
      end
      hold--;
      if (!cur_en && $urandom_range(0, 3) == 0) cur_en = 1'b1;
      else if (cur_en && $urandom_range(0, 39) == 0) cur_en = 1'b0;
      reset = ($urandom_range(0, 299) == 0);
      drive(cur_en, 1'($urandom_range(0, 1)), cur_cn, 10'($urandom_range(0, 1023)), $urandom());
      tick();
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
